adc_channel_averager: RTL and testbench
=======================================

# adc_channel_averager

Per-channel decimating averager that sits directly downstream of the SPI ADC controller. Each 12-bit conversion is tagged with its 3-bit channel address. The block accumulates 2^LOG2_AVG samples per channel and emits one averaged 12-bit result per channel per block. Results are queued in a small output FIFO with a valid/ready handshake toward the consumer (display, UART framer, or register bank).

## Interface
- LOG2_AVG, 3: log2 of samples averaged per result; legal range 0..6.
- NUM_CH, 8: number of channels tracked; legal range 1..8.
- FIFO_DEPTH, 4: output FIFO entries; power of two, at least 2.

- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- clr  in  1  synchronous flush of accumulators, pipeline, FIFO and overflow flag.
- in_valid  in  1  one-cycle strobe; a new conversion is present. No backpressure exists.
- in_data  in  12  conversion result.
- in_ch  in  3  channel address of in_data.
- out_valid  out  1  FIFO head holds a result.
- out_ready  in  1  consumer accepts the head when out_valid and out_ready are both high.
- out_data  out  12  averaged result at the FIFO head.
- out_ch  out  3  channel of out_data.
- overflow  out  1  sticky; a completed result was dropped because the FIFO was full.

## Operation
- Per channel the block keeps acc[ch] (12+LOG2_AVG bits, unsigned) and cnt[ch] (LOG2_AVG bits).
- Stage 1 (edge E): capture in_valid, in_data and in_ch into input registers.
- Stage 2 (edge E+1): read-modify-write on the captured channel.
  - sum = acc[ch] + data.
  - If cnt[ch] equals 2^LOG2_AVG-1: form result from sum, then clear acc[ch] and cnt[ch].
  - Otherwise: acc[ch] = sum and cnt[ch] = cnt[ch]+1.
  - The result and its channel are registered with a push flag.
- Stage 3 (edge E+2): the pushed result is written into the FIFO.
- Back-to-back samples on the same channel in consecutive cycles are exact, because the read-modify-write completes within one cycle and no forwarding is needed.
- A sample with in_ch at or above NUM_CH is discarded in stage 1 and changes no state.
- LOG2_AVG=0: every valid sample becomes a result (passthrough with latency).
- The FIFO is first-word-fall-through. out_data and out_ch are meaningful only while out_valid is high.
- FIFO full when a push arrives:
  - With no pop in the same cycle, the result is dropped and overflow is set.
  - With a pop in the same cycle, the push is accepted and overflow is unchanged.
- A pop on an empty FIFO is ignored.
- overflow is cleared only by rst or clr.

## Timing
- Reset values: out_valid=0, out_data=0, out_ch=0, overflow=0. All acc, cnt, pipeline valid bits and FIFO pointers are 0.
- Latency: the completing sample is sampled at edge E. out_valid is high after edge E+2 if the FIFO was empty.
- Throughput: one sample per clock sustained on any mix of channels.
- clr has priority over in_valid in the same cycle; that sample is lost.
  - clr invalidates samples in stages 1–2 and empties the FIFO.
  - out_valid is 0 after the clr edge.
- rst asserted mid-operation behaves identically to clr and also returns every output to its reset value.
- A pop takes effect at the edge where out_valid and out_ready are both high. The next entry, if any, is presented the following cycle.

## Configuration
- Macro: ADC_AVG_ROUND_EN.
- Defined: result = (sum + 2^(LOG2_AVG-1)) >> LOG2_AVG, saturated to 4095. For LOG2_AVG=0, result = sum.
- Undefined: result = sum >> LOG2_AVG (truncation). No saturation logic is needed.

## Test plan
- LOG2_AVG=3, ch0 samples 100..107 on consecutive cycles, out_ready=1:
  - one result out_ch=0 with out_valid exactly 2 edges after the 8th sample;
  - out_data=103 without ADC_AVG_ROUND_EN, 104 with it.
- Interleave ch0=4095 and ch5=0 for 16 samples:
  - expect results ch0=4095 and ch5=0 in completion order;
  - with rounding, ch0 saturates at 4095 and does not wrap.
- out_ready=0, generate 5 completed results with FIFO_DEPTH=4:
  - expect 4 entries retained and overflow=1;
  - then raise out_ready and drain the 4 in order; overflow stays 1 until clr.
- FIFO full with a pop and push in the same cycle: no overflow, and the FIFO stays at 4 entries.
- Feed 5 ch2 samples, pulse clr, then feed 8 ch2 samples of 200: exactly one result of 200; none from the pre-clr partial.
- in_ch=7 with NUM_CH=6: no result, no state change. Then assert rst mid-stream: all outputs 0 the next cycle and accumulation restarts from empty.

Source files
------------

// File: rtl/adc_channel_averager.sv
// adc_channel_averager: per-channel 2^LOG2_AVG sample averager feeding a FWFT result FIFO; define ADC_AVG_ROUND_EN for rounded, saturated averages
module adc_channel_averager #(
    parameter int LOG2_AVG   = 3,
    parameter int NUM_CH     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        in_valid,
    input  logic [11:0] in_data,
    input  logic [2:0]  in_ch,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [11:0] out_data,
    output logic [2:0]  out_ch,
    output logic        overflow
);
    localparam int AW = 12 + LOG2_AVG;
    localparam int CW = LOG2_AVG > 0 ? LOG2_AVG : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] CMAX = CW'((1 << LOG2_AVG) - 1);
    localparam logic [3:0] NCH = 4'(NUM_CH);
    logic          s1_valid;
    logic [11:0]   s1_data;
    logic [2:0]    s1_ch;
    logic [AW-1:0] acc [NUM_CH];
    logic [CW-1:0] cnt [NUM_CH];
    logic [AW-1:0] sum;
    logic          last;
    logic [11:0]   res;
    logic          s2_push;
    logic [11:0]   s2_data;
    logic [2:0]    s2_ch;
    logic [11:0]   mem_d [FIFO_DEPTH];
    logic [2:0]    mem_c [FIFO_DEPTH];
    logic [PW:0]   wr_ptr, rd_ptr;
    logic          full, pop, push;
    assign sum  = acc[s1_ch] + AW'(s1_data);
    assign last = LOG2_AVG == 0 || cnt[s1_ch] == CMAX;
`ifdef ADC_AVG_ROUND_EN
    localparam logic [AW:0] HALF = (AW+1)'((1 << LOG2_AVG) >> 1);
    logic [12:0] r13;
    assign r13 = 13'(({1'b0, sum} + HALF) >> LOG2_AVG);
    assign res = r13[12] ? 12'hfff : r13[11:0];
`else
    assign res = 12'(sum >> LOG2_AVG);
`endif
    assign out_valid = wr_ptr != rd_ptr;
    assign full      = wr_ptr == {~rd_ptr[PW], rd_ptr[PW-1:0]};
    assign pop       = out_valid && out_ready;
    assign push      = s2_push && (!full || pop);
    assign out_data  = out_valid ? mem_d[rd_ptr[PW-1:0]] : 12'd0;
    assign out_ch    = out_valid ? mem_c[rd_ptr[PW-1:0]] : 3'd0;
    // clr shares the reset path so in-flight samples, partial sums and queued results all vanish together
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_ch    <= '0;
            s2_push  <= 1'b0;
            s2_data  <= '0;
            s2_ch    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            overflow <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc[i] <= '0;
                cnt[i] <= '0;
            end
        end else begin
            s1_valid <= in_valid && {1'b0, in_ch} < NCH;
            if (in_valid && {1'b0, in_ch} < NCH) begin
                s1_data <= in_data;
                s1_ch   <= in_ch;
            end
            s2_push <= s1_valid && last;
            if (s1_valid) begin
                acc[s1_ch] <= last ? '0 : sum;
                cnt[s1_ch] <= last ? '0 : cnt[s1_ch] + CW'(1);
                s2_data    <= res;
                s2_ch      <= s1_ch;
            end
            if (push) begin
                mem_d[wr_ptr[PW-1:0]] <= s2_data;
                mem_c[wr_ptr[PW-1:0]] <= s2_ch;
                wr_ptr <= wr_ptr + (PW+1)'(1);
            end
            if (pop) rd_ptr <= rd_ptr + (PW+1)'(1);
            if (s2_push && full && !pop) overflow <= 1'b1;
        end
    end
endmodule

// File: tb/tb_adc_channel_averager.sv
// tb_adc_channel_averager: scoreboard bench for adc_channel_averager (LOG2_AVG=3, NUM_CH=6, FIFO_DEPTH=4)
module tb_adc_channel_averager;
    logic        clk = 0;
    logic        rst, clr, in_valid, out_ready;
    logic [11:0] in_data;
    logic [2:0]  in_ch;
    logic        out_valid, overflow;
    logic [11:0] out_data;
    logic [2:0]  out_ch;
    typedef struct { int ch; int data; } exp_t;
    exp_t sb[$];
    int n_chk = 0, n_fail = 0, n_pops = 0, p0;
`ifdef ADC_AVG_ROUND_EN
    localparam int T1_EXP = 104;
`else
    localparam int T1_EXP = 103;
`endif
    adc_channel_averager #(.LOG2_AVG(3), .NUM_CH(6), .FIFO_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .clr(clr), .in_valid(in_valid), .in_data(in_data), .in_ch(in_ch),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
        .overflow(overflow)
    );
    always #5 clk = ~clk;
    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask
    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask
    task automatic send(input int ch, input int data, input bit expect_out = 0, input int exp_data = 0);
        if (expect_out) sb.push_back('{ch, exp_data});
        in_valid = 1;
        in_ch    = 3'(ch);
        in_data  = 12'(data);
        @(posedge clk);
        #1;
        in_valid = 0;
    endtask
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_output: got ch %0d data %0d expected none", out_ch, out_data);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("out_ch", int'(out_ch), e.ch);
                chk("out_data", int'(out_data), e.data);
            end
            n_pops++;
        end
    end
    initial begin
        rst = 1; clr = 0; in_valid = 0; in_data = 0; in_ch = 0; out_ready = 1;
        idle(2);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_out_ch", int'(out_ch), 0);
        chk("rst_overflow", int'(overflow), 0);
        rst = 0;
        idle(1);
        for (int i = 0; i < 8; i++) send(0, 100 + i, i == 7, T1_EXP);
        chk("lat_e0", int'(out_valid), 0);
        idle(1);
        chk("lat_e1", int'(out_valid), 0);
        idle(1);
        chk("lat_e2", int'(out_valid), 1);
        idle(3);
        for (int i = 0; i < 16; i++)
            send(i % 2 ? 5 : 0, i % 2 ? 0 : 4095, i >= 14, i % 2 ? 0 : 4095);
        idle(4);
        out_ready = 0;
        for (int r = 0; r < 5; r++)
            for (int i = 0; i < 8; i++) send(r + 1, (r + 1) * 10, i == 7 && r < 4, (r + 1) * 10);
        idle(4);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_head_valid", int'(out_valid), 1);
        p0 = n_pops;
        out_ready = 1;
        idle(6);
        chk("ovf_drain_count", n_pops - p0, 4);
        chk("ovf_sticky", int'(overflow), 1);
        chk("ovf_empty", int'(out_valid), 0);
        clr = 1;
        idle(1);
        clr = 0;
        chk("clr_overflow", int'(overflow), 0);
        chk("clr_out_valid", int'(out_valid), 0);
        out_ready = 0;
        for (int r = 0; r < 4; r++)
            for (int i = 0; i < 8; i++) send(r, 11 * (r + 1), i == 7, 11 * (r + 1));
        for (int i = 0; i < 8; i++) send(5, 70, i == 7, 70);
        idle(1);
        p0 = n_pops;
        out_ready = 1;
        idle(1);
        out_ready = 0;
        chk("pp_overflow", int'(overflow), 0);
        chk("pp_one_pop", n_pops - p0, 1);
        idle(2);
        out_ready = 1;
        idle(6);
        chk("pp_total", n_pops - p0, 5);
        chk("pp_overflow_end", int'(overflow), 0);
        for (int i = 0; i < 5; i++) send(2, 999);
        clr = 1;
        idle(1);
        clr = 0;
        for (int i = 0; i < 8; i++) send(2, 200, i == 7, 200);
        idle(4);
        for (int i = 0; i < 4; i++) send(3, 80);
        for (int i = 0; i < 8; i++) send(7, 4000);
        for (int i = 0; i < 4; i++) send(3, 80, i == 3, 80);
        idle(4);
        out_ready = 0;
        for (int i = 0; i < 8; i++) send(1, 60);
        for (int i = 0; i < 3; i++) send(4, 1000);
        chk("pre_rst_valid", int'(out_valid), 1);
        chk("pre_rst_data", int'(out_data), 60);
        rst = 1;
        idle(1);
        chk("mid_rst_out_valid", int'(out_valid), 0);
        chk("mid_rst_out_data", int'(out_data), 0);
        chk("mid_rst_out_ch", int'(out_ch), 0);
        chk("mid_rst_overflow", int'(overflow), 0);
        rst = 0;
        out_ready = 1;
        for (int i = 0; i < 8; i++) send(4, 16, i == 7, 16);
        idle(5);
        chk("sb_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
